// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel-to-serial word transmitter with a valid/ready input.
// Each word is shifted out LSB first, one bit per clock. word_start marks bit 0,
// and GAP idle cycles can follow each word. The output strobes, busy and the
// sent-word counter are all registered.
module serial_word_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0,
  parameter int CNT_W = 16
) (
  input  logic             t_clk,
  input  logic             r,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             word_start,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam int IDX_W = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [3:0]       GAP_LAST = 4'(GAP - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAPS  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       gap_q, gap_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             bit_q, bit_d;
  logic             valid_q, valid_d;
  logic             ws_q, ws_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_s;
  logic             load_s;

  // Ready depends on state only: idle, last bit with no gap, or final gap cycle.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = 1'b1;
      SHIFT:   in_ready = (idx_q == LAST_IDX) && (GAP == 0);
      GAPS:    in_ready = (gap_q == GAP_LAST);
      default: in_ready = 1'b0;
    endcase
  end

  assign accept_s = in_valid && in_ready;

  // Next-state and next-output logic; a load presents bit 0 from the accept edge.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    sh_d    = sh_q;
    bit_d   = 1'b0;
    valid_d = 1'b0;
    ws_d    = 1'b0;
    cnt_d   = cnt_q;
    load_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          load_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (idx_q == LAST_IDX) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (accept_s) begin
            load_s = 1'b1;
          end else if (GAP == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAPS;
            gap_d   = 4'd0;
          end
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          bit_d   = sh_q[0];
          valid_d = 1'b1;
          sh_d    = sh_q >> 1;
        end
      end
      GAPS: begin
        if (gap_q == GAP_LAST) begin
          if (accept_s) begin
            load_s = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_s) begin
      state_d = SHIFT;
      idx_d   = '0;
      sh_d    = {1'b0, in_data[WIDTH-1:1]};
      bit_d   = in_data[0];
      valid_d = 1'b1;
      ws_d    = 1'b1;
    end else begin
      sh_d = sh_d;
    end
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset discards any partial word.
  always_ff @(posedge t_clk) begin
    if (r) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gap_q   <= 4'd0;
      sh_q    <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      ws_q    <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      ws_q    <= ws_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ser_bit    = bit_q;
  assign ser_valid  = valid_q;
  assign word_start = ws_q;
  assign busy       = busy_q;
  assign words_sent = cnt_q;

endmodule
